// File: rtl/lsu_controller.sv
// lsu_controller: RV32I load/store sequencer between execute stage and a
// req/ack word-wide data-memory bus. One access in flight at a time.
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses trap (IDLE->ERR, no bus cycle)
//   undefined -> misaligned low address bits are cleared and the access runs
module lsu_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        ready_o,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              is_store_q, is_store_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              req_illegal;
  logic [1:0]        req_off;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       load_ext;

  // Classify the incoming request and build its lane offset, byte enables and replicated data
  always_comb begin
    req_off     = addr_i[1:0];
    req_illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) ||
                  (is_store_i && funct3_i[2]);
`ifdef MISALIGN_TRAP_EN
    if ((funct3_i[1:0] == 2'b01 && addr_i[0]) ||
        (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00)) begin
      req_illegal = 1'b1;
    end
`else
    if (funct3_i[1:0] == 2'b01) begin
      req_off[0] = 1'b0;
    end else if (funct3_i[1:0] == 2'b10) begin
      req_off = 2'b00;
    end
`endif
    case (funct3_i[1:0])
      2'b00: begin
        req_be    = 4'b0001 << req_off;
        req_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        req_be    = 4'b0011 << {req_off[1], 1'b0};
        req_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = wdata_i;
      end
    endcase
  end

  // Select the addressed lane of the bus word and sign/zero-extend it by funct3
  always_comb begin
    case (off_q)
      2'b00:   byte_lane = mem_rdata_i[7:0];
      2'b01:   byte_lane = mem_rdata_i[15:8];
      2'b10:   byte_lane = mem_rdata_i[23:16];
      default: byte_lane = mem_rdata_i[31:24];
    endcase
    half_lane = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b010:  load_ext = mem_rdata_i;
      3'b100:  load_ext = {24'd0, byte_lane};
      3'b101:  load_ext = {16'd0, half_lane};
      default: load_ext = 32'd0;
    endcase
  end

  // Next-state and next-output computation; outputs derive from the next state so they leave flops
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    funct3_d    = funct3_q;
    off_d       = off_q;
    is_store_d  = is_store_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = 32'd0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          funct3_d    = funct3_i;
          off_d       = req_off;
          is_store_d  = is_store_i;
          mem_addr_d  = {addr_i[31:2], 2'b00};
          mem_be_d    = req_be;
          mem_wdata_d = req_wdata;
          state_d     = req_illegal ? ERR : REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          state_d = DONE;
          rdata_d = is_store_q ? 32'd0 : load_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d   = (state_d == IDLE);
    mem_req_d = (state_d == REQ);
    mem_we_d  = (state_d == REQ) && is_store_d;
    done_d    = (state_d == DONE) || (state_d == ERR);
    err_d     = (state_d == ERR);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      is_store_q  <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      is_store_q  <= is_store_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu_controller.sv
// tb_lsu_controller: directed bench for lsu_controller with hand-computed
// expectations. Honors MISALIGN_TRAP_EN for the misaligned-word step.
module tb_lsu_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        ready_o;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int total = 0;
  int bad   = 0;
  int reqCycles;

  lsu_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .ready_o     (ready_o),
    .is_store_i  (is_store_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request to the controller
  task automatic applyStimulus(input logic valid, input logic store,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
    req_valid_i = valid;
    is_store_i  = store;
    funct3_i    = f3;
    addr_i      = addr;
    wdata_i     = wdata;
  endtask

  // Compare one observed value against its expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i       = 1'b1;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'd0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    tick();
    checkOutput("rst_ready", {31'd0, ready_o}, 32'd1);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_err", {31'd0, err_o}, 32'd0);
    checkOutput("rst_rdata", rdata_o, 32'd0);
    checkOutput("rst_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rst_we", {31'd0, mem_we_o}, 32'd0);
    checkOutput("rst_addr", mem_addr_o, 32'd0);
    checkOutput("rst_be", {28'd0, mem_be_o}, 32'd0);
    checkOutput("rst_wdata", mem_wdata_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // LB 0x103, ack in the third REQ cycle
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    checkOutput("lb_req", {31'd0, mem_req_o}, 32'd1);
    checkOutput("lb_ready", {31'd0, ready_o}, 32'd0);
    checkOutput("lb_be", {28'd0, mem_be_o}, 32'h8);
    checkOutput("lb_addr", mem_addr_o, 32'h0000_0100);
    checkOutput("lb_we", {31'd0, mem_we_o}, 32'd0);
    tick();
    checkOutput("lb_wait_nodone", {31'd0, done_o}, 32'd0);
    tick();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h80FF_1234;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("lb_done", {31'd0, done_o}, 32'd1);
    checkOutput("lb_err", {31'd0, err_o}, 32'd0);
    checkOutput("lb_rdata", rdata_o, 32'hFFFF_FF80);
    checkOutput("lb_done_noreq", {31'd0, mem_req_o}, 32'd0);
    tick();
    checkOutput("lb_idle_done", {31'd0, done_o}, 32'd0);
    checkOutput("lb_idle_rdata", rdata_o, 32'd0);
    checkOutput("lb_idle_ready", {31'd0, ready_o}, 32'd1);

    // SH 0x202, ack in first REQ cycle, done at cycle 2
    applyStimulus(1'b1, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    checkOutput("sh_req", {31'd0, mem_req_o}, 32'd1);
    checkOutput("sh_we", {31'd0, mem_we_o}, 32'd1);
    checkOutput("sh_be", {28'd0, mem_be_o}, 32'hC);
    checkOutput("sh_wdata", mem_wdata_o, 32'hBEEF_BEEF);
    checkOutput("sh_addr", mem_addr_o, 32'h0000_0200);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h1111_2222;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("sh_done", {31'd0, done_o}, 32'd1);
    checkOutput("sh_err", {31'd0, err_o}, 32'd0);
    checkOutput("sh_rdata", rdata_o, 32'd0);
    tick();

    // LHU 0x0 with no ack: timeout after exactly 16 REQ cycles
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    reqCycles = 0;
    for (int i = 0; i < 40 && mem_req_o; i++) begin
      reqCycles++;
      tick();
    end
    checkOutput("to_cycles", reqCycles, 32'd16);
    checkOutput("to_done", {31'd0, done_o}, 32'd1);
    checkOutput("to_err", {31'd0, err_o}, 32'd1);
    checkOutput("to_rdata", rdata_o, 32'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    checkOutput("late_ack_done", {31'd0, done_o}, 32'd0);
    checkOutput("late_ack_ready", {31'd0, ready_o}, 32'd1);
    tick();
    checkOutput("late_ack_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("late_ack_done2", {31'd0, done_o}, 32'd0);
    mem_ack_i = 1'b0;

    // LW 0x6 (misaligned word)
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
`ifdef MISALIGN_TRAP_EN
    checkOutput("mis_noreq", {31'd0, mem_req_o}, 32'd0);
    checkOutput("mis_done", {31'd0, done_o}, 32'd1);
    checkOutput("mis_err", {31'd0, err_o}, 32'd1);
`else
    checkOutput("mis_req", {31'd0, mem_req_o}, 32'd1);
    checkOutput("mis_addr", mem_addr_o, 32'h0000_0004);
    checkOutput("mis_be", {28'd0, mem_be_o}, 32'hF);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h1234_5678;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("mis_done", {31'd0, done_o}, 32'd1);
    checkOutput("mis_err", {31'd0, err_o}, 32'd0);
    checkOutput("mis_rdata", rdata_o, 32'h1234_5678);
`endif
    tick();

    // Illegal funct3 load, then SB encoded with funct3=100
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    checkOutput("ill_ld_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("ill_ld_done", {31'd0, done_o}, 32'd1);
    checkOutput("ill_ld_err", {31'd0, err_o}, 32'd1);
    tick();
    checkOutput("ill_ld_ready", {31'd0, ready_o}, 32'd1);
    applyStimulus(1'b1, 1'b1, 3'b100, 32'h0000_0020, 32'h0000_00AA);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    checkOutput("ill_st_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("ill_st_done", {31'd0, done_o}, 32'd1);
    checkOutput("ill_st_err", {31'd0, err_o}, 32'd1);
    tick();

    // LH 0x2 sign-extends upper half; LBU 0x1 zero-extends byte 1
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    checkOutput("lh_be", {28'd0, mem_be_o}, 32'hC);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h8001_0000;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("lh_rdata", rdata_o, 32'hFFFF_8001);
    tick();
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    checkOutput("lbu_be", {28'd0, mem_be_o}, 32'h2);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h0000_F000;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("lbu_rdata", rdata_o, 32'h0000_00F0);
    tick();

    // SB 0x101 replicates the low byte
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_5655);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    checkOutput("sb_be", {28'd0, mem_be_o}, 32'h2);
    checkOutput("sb_wdata", mem_wdata_o, 32'h5555_5555);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("sb_done", {31'd0, done_o}, 32'd1);
    tick();

    // Reset pulsed mid-access, then a clean LW
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    checkOutput("rst_mid_req", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("rst_mid_noreq", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rst_mid_nodone", {31'd0, done_o}, 32'd0);
    checkOutput("rst_mid_ready", {31'd0, ready_o}, 32'd1);
    tick();
    checkOutput("rst_mid_nodone2", {31'd0, done_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_000C, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    checkOutput("post_rst_req", {31'd0, mem_req_o}, 32'd1);
    checkOutput("post_rst_addr", mem_addr_o, 32'h0000_000C);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hCAFE_F00D;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("post_rst_done", {31'd0, done_o}, 32'd1);
    checkOutput("post_rst_err", {31'd0, err_o}, 32'd0);
    checkOutput("post_rst_rdata", rdata_o, 32'hCAFE_F00D);
    tick();
    checkOutput("final_ready", {31'd0, ready_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
